exp_sequencer: RTL and testbench
================================

EXP_SEQUENCER -- requirements
Module: exp_sequencer

Interface
REQ-001 Parameter NUM_EXP, default 4: number of experiment slots sequenced (2..16).
REQ-002 Parameter TIMEOUT, default 10000: watchdog limit in clk cycles per experiment (>=2).
REQ-003 Parameter CNT_W, default 16: watchdog counter width; SHALL satisfy 2**CNT_W > TIMEOUT.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 go  input  1  start-run request, sampled in IDLE or DONE only.
REQ-007 enable_mask  input  NUM_EXP  experiment enable bits, captured on accepted go.
REQ-008 exp_done  input  NUM_EXP  per-experiment completion strobe.
REQ-009 exp_pass  input  NUM_EXP  per-experiment verdict, valid with exp_done.
REQ-010 exp_start  output  NUM_EXP  one-hot, one-cycle start pulse.
REQ-011 busy  output  1  high in every state except IDLE and DONE.
REQ-012 cur_idx  output  $clog2(NUM_EXP)+1  index of the slot being processed.
REQ-013 pass_cnt, fail_cnt  output  $clog2(NUM_EXP+1) each  verdict tallies of the current run.
REQ-014 timeout_mask  output  NUM_EXP  bit i set when slot i timed out.
REQ-015 all_done  output  1  level, high in DONE.

Function
REQ-016 FSM states SHALL be IDLE, SELECT, START, WAIT, NEXT, DONE; all outputs registered or decoded from registered state only.
REQ-017 IDLE/DONE with go=1: latch enable_mask, cur_idx<=0, clear pass_cnt, fail_cnt, timeout_mask, go to SELECT; go in any other state ignored.
REQ-018 SELECT: cur_idx==NUM_EXP -> DONE; else mask[cur_idx]==0 -> cur_idx+1, stay SELECT (one slot skipped per cycle); else -> START.
REQ-019 START: exp_start[cur_idx]=1 for exactly this one cycle, watchdog<=0, -> WAIT.
REQ-020 WAIT: watchdog +1 per cycle; exp_done[cur_idx]=1 -> exp_pass[cur_idx] ? pass_cnt+1 : fail_cnt+1, -> NEXT.
REQ-021 WAIT: watchdog==TIMEOUT-1 with no done -> fail_cnt+1, timeout_mask[cur_idx]<=1, -> NEXT.
REQ-022 Done and timeout in same cycle: done wins, timeout_mask not set.
REQ-023 exp_done/exp_pass bits of slots other than cur_idx SHALL be ignored in all states; exp_done outside WAIT ignored.
REQ-024 NEXT: cur_idx+1, -> SELECT.
REQ-025 Latency: go accepted at edge t -> exp_start[0] high in cycle t+2 when mask[0]=1.
REQ-026 exp_start SHALL be all-zero in every state other than START.
REQ-027 DONE holds pass_cnt, fail_cnt, timeout_mask, cur_idx==NUM_EXP stable until next accepted go.
REQ-028 enable_mask changes after capture SHALL not affect the current run.
REQ-029 Invariant at DONE: pass_cnt+fail_cnt == popcount(captured mask).

Reset
REQ-030 rst=1 asynchronously forces IDLE; exp_start=0, busy=0, cur_idx=0, pass_cnt=0, fail_cnt=0, timeout_mask=0, all_done=0, watchdog=0, captured mask=0.
REQ-031 Reset asserted mid-run (any state) aborts with no further exp_start pulse; after release, go required to restart.

Verification (NUM_EXP=4, TIMEOUT=8)
REQ-032 mask=4'b1111, each slot done+pass 3 cycles after its start -> four single start pulses in order 0..3, all_done=1, pass_cnt=4, fail_cnt=0.
REQ-033 mask=4'b0101, slot0 pass, slot2 fail -> starts only on slots 0,2; pass_cnt=1, fail_cnt=1, timeout_mask=0.
REQ-034 mask=4'b0010, slot1 never done -> fail after 8 WAIT cycles, timeout_mask=4'b0010, fail_cnt=1, all_done=1.
REQ-035 slot0 done asserted on the timeout cycle (watchdog=7) -> counted by verdict, timeout_mask[0]=0.
REQ-036 mask=4'b0000 -> DONE 5 cycles after go with no exp_start, counts 0; go during WAIT of another run -> ignored.
REQ-037 rst pulsed while in WAIT on slot 2 -> all outputs at reset values same cycle; no start pulses until new go.

Source files
------------

// File: rtl/exp_sequencer.sv
// exp_sequencer
// Walks through NUM_EXP experiment slots in index order. Each enabled slot
// gets a one-cycle start pulse and is then watched until it reports done or
// its watchdog expires. Verdicts are tallied per run.
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-high reset
//   go           - start a run (honoured only in IDLE or DONE)
//   enable_mask  - slot enables, captured when go is accepted
//   exp_done     - per-slot completion strobe
//   exp_pass     - per-slot verdict, qualified by exp_done
//   exp_start    - one-hot start pulse, only ever in START
//   busy         - run in progress (not IDLE / DONE)
//   cur_idx      - slot currently processed (NUM_EXP once the run finished)
//   pass_cnt     - passing slots in this run
//   fail_cnt     - failing slots in this run (verdict fail or timeout)
//   timeout_mask - slots whose watchdog expired in this run
//   all_done     - level, high in DONE
module exp_sequencer #(
    parameter int NUM_EXP = 4,
    parameter int TIMEOUT = 10000,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           go,
    input  logic [NUM_EXP-1:0]             enable_mask,
    input  logic [NUM_EXP-1:0]             exp_done,
    input  logic [NUM_EXP-1:0]             exp_pass,
    output logic [NUM_EXP-1:0]             exp_start,
    output logic                           busy,
    output logic [$clog2(NUM_EXP):0]       cur_idx,
    output logic [$clog2(NUM_EXP+1)-1:0]   pass_cnt,
    output logic [$clog2(NUM_EXP+1)-1:0]   fail_cnt,
    output logic [NUM_EXP-1:0]             timeout_mask,
    output logic                           all_done
);

    localparam int IDX_W   = $clog2(NUM_EXP) + 1;
    localparam int TALLY_W = $clog2(NUM_EXP + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [NUM_EXP-1:0]   mask_r;
    logic [IDX_W-1:0]     cur_idx_r;
    logic [TALLY_W-1:0]   pass_cnt_r;
    logic [TALLY_W-1:0]   fail_cnt_r;
    logic [NUM_EXP-1:0]   timeout_mask_r;
    logic [CNT_W-1:0]     watchdog_r;
    logic [NUM_EXP-1:0]   cur_onehot_s;
    logic                 at_end_s;
    logic                 mask_sel_s;
    logic                 done_sel_s;
    logic                 pass_sel_s;
    logic                 wd_expired_s;

    // Pick bit idx out of vec; idx values beyond the vector select nothing,
    // which keeps the cur_idx==NUM_EXP case safe without wide indexing.
    function automatic logic sel_bit(input logic [NUM_EXP-1:0] vec,
                                     input logic [IDX_W-1:0]   idx);
        logic bit_v;
        bit_v = 1'b0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (idx == IDX_W'(i)) begin
                bit_v = vec[i];
            end else begin
                bit_v = bit_v;
            end
        end
        return bit_v;
    endfunction

    // Decode of the current slot index and the per-slot qualifiers.
    always_comb begin
        cur_onehot_s = {NUM_EXP{1'b0}};
        for (int i = 0; i < NUM_EXP; i++) begin
            if (cur_idx_r == IDX_W'(i)) begin
                cur_onehot_s[i] = 1'b1;
            end else begin
                cur_onehot_s[i] = 1'b0;
            end
        end
        at_end_s     = (cur_idx_r == IDX_W'(NUM_EXP));
        mask_sel_s   = sel_bit(mask_r, cur_idx_r);
        // Only the strobe of the slot being watched is ever looked at.
        done_sel_s   = sel_bit(exp_done, cur_idx_r);
        pass_sel_s   = sel_bit(exp_pass, cur_idx_r);
        wd_expired_s = (watchdog_r == CNT_W'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    state_next_s = ST_SELECT;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_SELECT: begin
                if (at_end_s) begin
                    state_next_s = ST_DONE;
                end else if (mask_sel_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_SELECT;
                end
            end
            ST_START: state_next_s = ST_WAIT;
            ST_WAIT: begin
                // A done arriving on the expiry cycle still leaves via NEXT.
                if (done_sel_s || wd_expired_s) begin
                    state_next_s = ST_NEXT;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_NEXT: state_next_s = ST_SELECT;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        exp_start = {NUM_EXP{1'b0}};
        busy      = 1'b0;
        all_done  = 1'b0;
        case (state_r)
            ST_IDLE:  busy = 1'b0;
            ST_DONE:  all_done = 1'b1;
            ST_START: begin
                exp_start = cur_onehot_s;
                busy      = 1'b1;
            end
            ST_SELECT, ST_WAIT, ST_NEXT: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Run datapath: captured mask, slot index, watchdog and tallies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_r         <= {NUM_EXP{1'b0}};
            cur_idx_r      <= {IDX_W{1'b0}};
            pass_cnt_r     <= {TALLY_W{1'b0}};
            fail_cnt_r     <= {TALLY_W{1'b0}};
            timeout_mask_r <= {NUM_EXP{1'b0}};
            watchdog_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        mask_r         <= enable_mask;
                        cur_idx_r      <= {IDX_W{1'b0}};
                        pass_cnt_r     <= {TALLY_W{1'b0}};
                        fail_cnt_r     <= {TALLY_W{1'b0}};
                        timeout_mask_r <= {NUM_EXP{1'b0}};
                    end
                end
                ST_SELECT: begin
                    // Disabled slots are skipped one per cycle.
                    if (!at_end_s && !mask_sel_s) begin
                        cur_idx_r <= cur_idx_r + IDX_W'(1);
                    end
                end
                ST_START: watchdog_r <= {CNT_W{1'b0}};
                ST_WAIT: begin
                    watchdog_r <= watchdog_r + CNT_W'(1);
                    if (done_sel_s) begin
                        if (pass_sel_s) begin
                            pass_cnt_r <= pass_cnt_r + TALLY_W'(1);
                        end else begin
                            fail_cnt_r <= fail_cnt_r + TALLY_W'(1);
                        end
                    end else if (wd_expired_s) begin
                        fail_cnt_r     <= fail_cnt_r + TALLY_W'(1);
                        timeout_mask_r <= timeout_mask_r | cur_onehot_s;
                    end
                end
                ST_NEXT: cur_idx_r <= cur_idx_r + IDX_W'(1);
                default: cur_idx_r <= cur_idx_r;
            endcase
        end
    end

    assign cur_idx      = cur_idx_r;
    assign pass_cnt     = pass_cnt_r;
    assign fail_cnt     = fail_cnt_r;
    assign timeout_mask = timeout_mask_r;

endmodule

// File: tb/tb_exp_sequencer.sv
// Directed bench for exp_sequencer (NUM_EXP=4, TIMEOUT=8). A table of runs
// is replayed with a small slot responder; hand-written sequences cover
// latency, empty-mask timing, watchdog expiry timing, go during a run and
// reset in the middle of a run.
module tb_exp_sequencer;

    localparam int NUM_EXP = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 8;

    logic       clk;
    logic       rst;
    logic       go;
    logic [3:0] enable_mask;
    logic [3:0] exp_done;
    logic [3:0] exp_pass;
    logic [3:0] exp_start;
    logic       busy;
    logic [2:0] cur_idx;
    logic [2:0] pass_cnt;
    logic [2:0] fail_cnt;
    logic [3:0] timeout_mask;
    logic       all_done;

    exp_sequencer #(.NUM_EXP(NUM_EXP), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .go(go), .enable_mask(enable_mask),
        .exp_done(exp_done), .exp_pass(exp_pass), .exp_start(exp_start),
        .busy(busy), .cur_idx(cur_idx), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .timeout_mask(timeout_mask), .all_done(all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] mask;     // enable_mask applied with go
        logic [3:0] pass;     // verdict each slot reports
        logic [3:0] hang;     // slots that never report done
        int         delay;    // cycles from start pulse to done
        logic       noise;    // strobe the other slots' done/pass lines
        logic [2:0] e_pass;
        logic [2:0] e_fail;
        logic [3:0] e_tmo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the current run finish while counting start pulses.
    task automatic wait_all_done(input string name, input int budget, output int starts);
        int c;
        starts = 0;
        c = 0;
        while (!all_done && c < budget) begin
            if (exp_start != 4'b0000) starts++;
            tick();
            c++;
        end
        check({name, " all_done reached"}, 32'(all_done), 32'd1);
    endtask

    // One table run: go, respond to each start pulse, compare the tallies.
    task automatic run_vec(input int idx, input vec_t v);
        logic [3:0] seen;
        int nstart, last, cur, cnt;
        logic pend, onehot_ok, order_ok, busy_ok, finished;
        string tag;
        tag = $sformatf("vec%0d", idx);
        seen = 4'b0000; nstart = 0; last = -1; cur = -1; cnt = 0;
        pend = 1'b0; onehot_ok = 1'b1; order_ok = 1'b1; busy_ok = 1'b1; finished = 1'b0;
        enable_mask = v.mask;
        go = 1'b1;
        tick();
        go = 1'b0;
        enable_mask = ~v.mask;  // must not disturb the captured run
        for (int c = 0; c < 300 && !finished; c++) begin
            if (all_done) begin
                finished = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                exp_done = 4'b0000;
                exp_pass = 4'b0000;
                if (exp_start != 4'b0000) begin
                    if (!$onehot(exp_start)) onehot_ok = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        if (exp_start[i]) begin
                            if (i <= last) order_ok = 1'b0;
                            last = i;
                            cur = i;
                            seen[i] = 1'b1;
                        end
                    end
                    nstart++;
                    pend = !v.hang[cur];
                    cnt = v.delay - 1;
                end else if (pend) begin
                    if (cnt == 0) begin
                        exp_done[cur] = 1'b1;
                        exp_pass[cur] = v.pass[cur];
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (v.noise) begin
                    for (int i = 0; i < 4; i++) begin
                        if (i != cur) begin
                            exp_done[i] = 1'b1;
                            exp_pass[i] = 1'b1;
                        end
                    end
                end
                tick();
            end
        end
        exp_done = 4'b0000;
        exp_pass = 4'b0000;
        check({tag, " all_done"}, 32'(finished), 32'd1);
        check({tag, " pass_cnt"}, 32'(pass_cnt), 32'(v.e_pass));
        check({tag, " fail_cnt"}, 32'(fail_cnt), 32'(v.e_fail));
        check({tag, " timeout_mask"}, 32'(timeout_mask), 32'(v.e_tmo));
        check({tag, " started slots"}, 32'(seen), 32'(v.mask));
        check({tag, " start count"}, 32'(nstart), 32'($countones(v.mask)));
        check({tag, " onehot"}, 32'(onehot_ok), 32'd1);
        check({tag, " order"}, 32'(order_ok), 32'd1);
        check({tag, " busy during run"}, 32'(busy_ok), 32'd1);
        check({tag, " cur_idx at done"}, 32'(cur_idx), 32'd4);
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        check({tag, " tally sum"}, 32'(pass_cnt) + 32'(fail_cnt), 32'($countones(v.mask)));
    endtask

    initial begin
        int starts, k;
        logic quiet_ok;

        //          mask     pass     hang     dly noise  pass  fail  tmo
        vecs[0] = '{4'b1111, 4'b1111, 4'b0000, 3, 1'b0, 3'd4, 3'd0, 4'b0000};
        vecs[1] = '{4'b0101, 4'b0001, 4'b0000, 3, 1'b0, 3'd1, 3'd1, 4'b0000};
        vecs[2] = '{4'b0010, 4'b0000, 4'b0010, 3, 1'b0, 3'd0, 3'd1, 4'b0010};
        vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 3, 1'b1, 3'd0, 3'd0, 4'b0000};
        vecs[4] = '{4'b1011, 4'b1001, 4'b0000, 1, 1'b1, 3'd2, 3'd1, 4'b0000};
        vecs[5] = '{4'b1100, 4'b0100, 4'b1000, 7, 1'b1, 3'd1, 3'd1, 4'b1000};
        vecs[6] = '{4'b0001, 4'b0001, 4'b0000, 8, 1'b0, 3'd1, 3'd0, 4'b0000};
        vecs[7] = '{4'b0001, 4'b0000, 4'b0000, 8, 1'b1, 3'd0, 3'd1, 4'b0000};

        rst = 1'b1; go = 1'b0; enable_mask = 4'b0000;
        exp_done = 4'b0000; exp_pass = 4'b0000;
        tick(); tick();
        check("reset exp_start", 32'(exp_start), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset cur_idx", 32'(cur_idx), 32'd0);
        check("reset pass_cnt", 32'(pass_cnt), 32'd0);
        check("reset fail_cnt", 32'(fail_cnt), 32'd0);
        check("reset timeout_mask", 32'(timeout_mask), 32'd0);
        check("reset all_done", 32'(all_done), 32'd0);
        rst = 1'b0;
        tick();

        // Latency: go at edge t, start on slot 0 right after edge t+1.
        enable_mask = 4'b0001; go = 1'b1;
        tick();
        go = 1'b0;
        check("latency select no start", 32'(exp_start), 32'd0);
        check("latency busy", 32'(busy), 32'd1);
        tick();
        check("latency start slot0", 32'(exp_start), 32'b0001);
        tick();
        check("latency single pulse", 32'(exp_start), 32'd0);
        exp_done = 4'b0001; exp_pass = 4'b0001;
        tick();
        exp_done = 4'b0000; exp_pass = 4'b0000;
        wait_all_done("latency", 20, starts);
        check("latency pass_cnt", 32'(pass_cnt), 32'd1);

        // Empty mask: DONE five edges after go, no start pulse.
        enable_mask = 4'b0000; go = 1'b1;
        tick();
        go = 1'b0;
        quiet_ok = (exp_start == 4'b0000) && !all_done;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (exp_start != 4'b0000 || all_done) quiet_ok = 1'b0;
        end
        tick();
        check("empty quiet before done", 32'(quiet_ok && exp_start == 4'b0000), 32'd1);
        check("empty not done at t+4", 32'(all_done), 32'd0);
        tick();
        check("empty done at t+5", 32'(all_done), 32'd1);
        check("empty counts", 32'(pass_cnt) + 32'(fail_cnt), 32'd0);

        // Watchdog expiry: tally moves exactly after the eighth WAIT cycle.
        enable_mask = 4'b0010; go = 1'b1;
        tick();
        go = 1'b0;
        k = 0;
        while (exp_start == 4'b0000 && k < 20) begin tick(); k++; end
        check("timeout start slot1", 32'(exp_start), 32'b0010);
        for (int i = 0; i < 8; i++) tick();
        check("timeout fail_cnt before expiry", 32'(fail_cnt), 32'd0);
        check("timeout mask before expiry", 32'(timeout_mask), 32'd0);
        tick();
        check("timeout fail_cnt after expiry", 32'(fail_cnt), 32'd1);
        check("timeout mask after expiry", 32'(timeout_mask), 32'b0010);
        wait_all_done("timeout", 20, starts);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // go while a run is waiting on slot 0 must be ignored.
        enable_mask = 4'b0001; go = 1'b1;
        tick();
        go = 1'b0;
        k = 0;
        while (exp_start == 4'b0000 && k < 20) begin tick(); k++; end
        tick();
        go = 1'b1; enable_mask = 4'b1111;
        tick(); tick(); tick();
        go = 1'b0;
        exp_done = 4'b0001; exp_pass = 4'b0001;
        tick();
        exp_done = 4'b0000; exp_pass = 4'b0000;
        wait_all_done("go ignored", 40, starts);
        check("go ignored extra starts", 32'(starts), 32'd0);
        check("go ignored pass_cnt", 32'(pass_cnt), 32'd1);
        check("go ignored fail_cnt", 32'(fail_cnt), 32'd0);
        // DONE keeps its results while strobes keep arriving.
        exp_done = 4'b1111; exp_pass = 4'b0000;
        tick(); tick(); tick();
        exp_done = 4'b0000;
        check("done hold pass_cnt", 32'(pass_cnt), 32'd1);
        check("done hold fail_cnt", 32'(fail_cnt), 32'd0);
        check("done hold cur_idx", 32'(cur_idx), 32'd4);

        // Reset in the middle of WAIT on slot 2.
        enable_mask = 4'b0100; go = 1'b1;
        tick();
        go = 1'b0;
        k = 0;
        while (exp_start == 4'b0000 && k < 20) begin tick(); k++; end
        check("abort start slot2", 32'(exp_start), 32'b0100);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort cur_idx", 32'(cur_idx), 32'd0);
        check("abort all outputs", {exp_start, pass_cnt, fail_cnt, timeout_mask, all_done}, 32'd0);
        tick();
        rst = 1'b0;
        quiet_ok = 1'b1;
        exp_done = 4'b1111; exp_pass = 4'b1111;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (exp_start != 4'b0000 || busy || all_done) quiet_ok = 1'b0;
        end
        exp_done = 4'b0000; exp_pass = 4'b0000;
        check("abort idle without go", 32'(quiet_ok), 32'd1);
        run_vec(8, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
